sonar_trigger_ctrl: RTL and testbench
=====================================

Name: sonar_trigger_ctrl

Overview:
Upstream stage of the ultrasonic ranger path. Periodically issues the sensor trigger pulse and synchronises the raw asynchronous echo pin. It gates the echo into a clean, single-pulse-per-frame `echo_out` that drives the pulse-width counter stage directly. Missing and over-long echoes are flagged so the counter stage never sees a stuck or stale pulse.

Parameters:
- TRIG_CYCLES, 500: trigger high time in clocks (10 us at 50 MHz).
- PERIOD_CYCLES, 3000000: frame period in clocks, measured from trigger rise (60 ms).
- ECHO_WAIT_MAX, 1500000: maximum clocks from trigger fall to echo rise before `no_echo` fires.
- ECHO_MAX, 1250000: maximum echo high time in clocks before `timeout` fires.
- CNT_W, 32: width of all internal counters; must hold the largest parameter.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- RESET_N  input  1  synchronous active-low reset.
- enable  input  1  run periodic measurement frames while high.
- echo_in  input  1  raw echo pin, asynchronous to CLOCK_50.
- trig_out  output  1  sensor trigger.
- echo_out  output  1  synchronised, gated echo; at most one high pulse per frame.
- frame_start  output  1  one-cycle pulse on the cycle `trig_out` rises.
- echo_done  output  1  one-cycle pulse when a valid echo ends normally.
- no_echo  output  1  one-cycle pulse when the echo-rise wait expires.
- timeout  output  1  one-cycle pulse when the echo exceeds ECHO_MAX.
- busy  output  1  high in every state except IDLE.

Behaviour:
- **Reset.** Reset is synchronous and active-low: RESET_N is sampled on the CLOCK_50 rising edge. While it is low:
  - state goes to IDLE;
  - all counters, both sync flops and the echo delay flop clear to 0;
  - every output is 0.
- **Reset mid-frame.** Same as above. `trig_out` and `echo_out` drop at the first edge where RESET_N is sampled low.
- **Synchroniser.** `echo_in` passes through 2 flops to give `echo_s`, then 1 delay flop to give `echo_d`. Rise = `echo_s` & ~`echo_d`. Fall = ~`echo_s` & `echo_d`.
- **Echo latency.** Fixed at 3 clocks for both edges. A clean `echo_in` high of N cycles (N < ECHO_MAX) yields `echo_out` high for exactly N cycles.
- **Period counter.** Clears on trigger rise and increments every cycle outside IDLE.
- **State IDLE.**
  - If `enable` = 1: go to TRIG next cycle, assert `frame_start`, set `trig_out` = 1.
- **State TRIG.**
  - `trig_out` is high for exactly TRIG_CYCLES cycles, then goes to WAIT_RISE.
- **State WAIT_RISE.**
  - Only a Rise event is accepted. An `echo_s` that is already high on entry is ignored until it falls and rises again.
  - On Rise: go to ECHO and set `echo_out` = 1.
  - If ECHO_WAIT_MAX cycles elapse without a Rise: pulse `no_echo` and go to HOLDOFF.
- **State ECHO.**
  - On Fall: clear `echo_out`, pulse `echo_done`, go to HOLDOFF.
  - If `echo_out` has been high ECHO_MAX cycles: clear `echo_out`, pulse `timeout`, go to HOLDOFF. `echo_done` is not pulsed.
  - Fall and ECHO_MAX expiry on the same cycle: Fall wins (`echo_done` only).
- **State HOLDOFF.** Exits when the period counter is ≥ PERIOD_CYCLES−1 and `echo_s` = 0.
  - If `echo_s` is still high, the exit is extended; there is no retrigger while the echo is high.
  - Exit to TRIG if `enable` = 1, else to IDLE.
- **Enable deassert mid-frame.** The current frame completes through HOLDOFF, then the block goes to IDLE. No partial trigger is ever issued.
- **Frame period.** Trigger rise to trigger rise is exactly PERIOD_CYCLES clocks when the echo has ended.
- **Pulse exclusivity.** `no_echo`, `timeout` and `echo_done` are mutually exclusive, at most one per frame.
- **Width.** Counters saturate and never wrap, since each is bounded by its parameter.

Test Plan:
All scenarios use TRIG_CYCLES=5, PERIOD_CYCLES=200, ECHO_WAIT_MAX=50, ECHO_MAX=60.
1. Reset, `enable`=1, echo high 20 cycles starting 10 cycles after trig fall:
   - `frame_start` 1 cycle and `trig_out` high exactly 5 cycles;
   - `echo_out` high exactly 20 cycles, rising 3 clocks after `echo_in`;
   - one `echo_done`;
   - next `frame_start` exactly 200 cycles after the first.
2. No echo:
   - `no_echo` pulses exactly 50 cycles after trig fall;
   - `echo_out` stays 0;
   - next trigger lands at 200.
3. Echo held high 100 cycles:
   - `echo_out` high exactly 60 cycles, then a `timeout` pulse and no `echo_done`;
   - next trigger delayed until `echo_s` is low.
4. `echo_in` already high before trigger and falling during WAIT_RISE, then rising again: only the second rise produces `echo_out`.
5. `enable` dropped during ECHO: the echo completes, then IDLE with `busy`=0 and no further `frame_start`. Re-raising `enable` gives `frame_start` one cycle later.
6. RESET_N low for 1 cycle mid-TRIG and separately mid-ECHO: `trig_out`/`echo_out` are 0 on the next edge, all outputs are 0, and the block restarts cleanly.

Source files
------------

// File: rtl/sonar_trigger_ctrl.sv
// Ultrasonic ranger front end: periodic trigger generation, echo pin synchroniser,
// and a gated echo that reaches the pulse-width counter at most once per frame.
module sonar_trigger_ctrl #(
    parameter int unsigned TRIG_CYCLES   = 500,
    parameter int unsigned PERIOD_CYCLES = 3000000,
    parameter int unsigned ECHO_WAIT_MAX = 1500000,
    parameter int unsigned ECHO_MAX      = 1250000,
    parameter int unsigned CNT_W         = 32
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic enable,
    input  logic echo_in,
    output logic trig_out,
    output logic echo_out,
    output logic frame_start,
    output logic echo_done,
    output logic no_echo,
    output logic timeout,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        ECHO,
        HOLDOFF
    } state_t;

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ECHO_WAIT_MAX - 1);
    localparam logic [CNT_W-1:0] ECHO_LAST = CNT_W'(ECHO_MAX - 1);
    localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(PERIOD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic             sync1_q, echo_s_q, echo_d_q;
    logic             frame_start_q, frame_start_d;
    logic             echo_done_q, echo_done_d;
    logic             no_echo_q, no_echo_d;
    logic             timeout_q, timeout_d;
    logic             rise, fall;

    assign rise = echo_s_q & ~echo_d_q;
    assign fall = ~echo_s_q & echo_d_q;

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            per_q         <= '0;
            sync1_q       <= 1'b0;
            echo_s_q      <= 1'b0;
            echo_d_q      <= 1'b0;
            frame_start_q <= 1'b0;
            echo_done_q   <= 1'b0;
            no_echo_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            per_q         <= per_d;
            sync1_q       <= echo_in;
            echo_s_q      <= sync1_q;
            echo_d_q      <= echo_s_q;
            frame_start_q <= frame_start_d;
            echo_done_q   <= echo_done_d;
            no_echo_q     <= no_echo_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        per_d         = per_q;
        frame_start_d = 1'b0;
        echo_done_d   = 1'b0;
        no_echo_d     = 1'b0;
        timeout_d     = 1'b0;

        // Period counter parks at its terminal value so a long echo cannot wrap it.
        if (state_q != IDLE && per_q < PER_LAST) begin
            per_d = per_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d       = TRIG;
                    cnt_d         = '0;
                    per_d         = '0;
                    frame_start_d = 1'b1;
                end
            end
            TRIG: begin
                if (cnt_q >= TRIG_LAST) begin
                    state_d = WAIT_RISE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_RISE: begin
                // Edge-only acceptance: a level already high on entry never opens the gate.
                if (rise) begin
                    state_d = ECHO;
                    cnt_d   = '0;
                end else if (cnt_q >= WAIT_LAST) begin
                    state_d   = HOLDOFF;
                    no_echo_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ECHO: begin
                if (fall) begin
                    state_d     = HOLDOFF;
                    echo_done_d = 1'b1;
                end else if (cnt_q >= ECHO_LAST) begin
                    state_d   = HOLDOFF;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLDOFF: begin
                if (per_q >= PER_LAST && !echo_s_q) begin
                    if (enable) begin
                        state_d       = TRIG;
                        cnt_d         = '0;
                        per_d         = '0;
                        frame_start_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign trig_out    = (state_q == TRIG);
    assign echo_out    = (state_q == ECHO);
    assign busy        = (state_q != IDLE);
    assign frame_start = frame_start_q;
    assign echo_done   = echo_done_q;
    assign no_echo     = no_echo_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_sonar_trigger_ctrl.sv
// Bench for sonar_trigger_ctrl: vector table, directed multi-cycle frames and a
// random echo/enable run checked against a frame-level event model.
module tb_sonar_trigger_ctrl;

    localparam int TRIG = 5;
    localparam int PER  = 200;
    localparam int WMAX = 50;
    localparam int EMAX = 60;
    localparam int N    = 3000;

    logic clk = 1'b0;
    logic rst_n, en, ein;
    logic trig_out, echo_out, frame_start, echo_done, no_echo, timeout, busy;
    logic [6:0] vec;
    int checks = 0;
    int errors = 0;

    sonar_trigger_ctrl #(
        .TRIG_CYCLES(TRIG), .PERIOD_CYCLES(PER), .ECHO_WAIT_MAX(WMAX),
        .ECHO_MAX(EMAX), .CNT_W(32)
    ) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .enable(en), .echo_in(ein),
        .trig_out(trig_out), .echo_out(echo_out), .frame_start(frame_start),
        .echo_done(echo_done), .no_echo(no_echo), .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    // {trig, echo_out, frame_start, echo_done, no_echo, timeout, busy}
    assign vec = {trig_out, echo_out, frame_start, echo_done, no_echo, timeout, busy};

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       ein;
        int         n;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[32];
    int   nv = 0;

    bit         ein_a[N];
    bit         en_a[N];
    logic [6:0] exp_a[N];

    int r_trig, r_eout, r_efirst, r_done, r_done_k, r_ne, r_to, r_to_k, r_next, r_idle;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic i, input int n, input logic [6:0] x);
        tbl[nv].rst_n = r;
        tbl[nv].en    = e;
        tbl[nv].ein   = i;
        tbl[nv].n     = n;
        tbl[nv].exp   = x;
        nv++;
    endtask

    // Runs from the frame_start cycle (k=0); echo high on [a0,a1) and [b0,b1),
    // enable dropped from k=drop onward (drop<0: never). Stops at next frame_start.
    task automatic run_frame(input int a0, input int a1, input int b0, input int b1,
                             input int drop, input int limit);
        r_trig = 0; r_eout = 0; r_efirst = -1; r_done = 0; r_done_k = -1;
        r_ne = 0; r_to = 0; r_to_k = -1; r_next = -1; r_idle = -1;
        for (int k = 0; k <= limit; k++) begin
            if (k > 0 && frame_start === 1'b1) begin
                r_next = k;
                break;
            end
            if (trig_out) r_trig++;
            if (echo_out) begin
                r_eout++;
                if (r_efirst < 0) r_efirst = k;
            end
            if (echo_done) begin r_done++; r_done_k = k; end
            if (no_echo) r_ne++;
            if (timeout) begin r_to++; r_to_k = k; end
            if (!busy && r_idle < 0) r_idle = k;
            ein = (k >= a0 && k < a1) || (k >= b0 && k < b1);
            en  = !(drop >= 0 && k >= drop);
            tick();
        end
    endtask

    task automatic start_frame(input string name);
        en = 1'b1;
        tick();
        chk(name, 32'(frame_start), 1);
    endtask

    task automatic go_idle();
        en  = 1'b0;
        ein = 1'b0;
        for (int k = 0; k < 1000 && busy; k++) tick();
        chk("idle_reached", 32'(busy), 0);
        repeat (3) tick();
    endtask

    function automatic bit einv(input int i);
        if (i < 0 || i >= N) return 1'b0;
        return ein_a[i];
    endfunction

    function automatic void setb(input int i, input int b);
        if (i >= 0 && i < N) exp_a[i][b] = 1'b1;
    endfunction

    // Frame-level model: events located by scanning the recorded echo waveform.
    // echo_s in cycle t equals echo_in driven in cycle t-2.
    task automatic build_model();
        int c, s, rw, e0, fw, he, cx;
        for (int i = 0; i < N; i++) exp_a[i] = '0;
        c = 0;
        while (c < N) begin
            if (!en_a[c]) begin c++; continue; end
            s = c + 1;
            setb(s, 4);
            for (int k = 0; k < TRIG; k++) setb(s + k, 6);
            rw = -1;
            for (int w = s + TRIG; w < s + TRIG + WMAX; w++)
                if (rw < 0 && einv(w - 2) && !einv(w - 3)) rw = w;
            if (rw >= 0) begin
                e0 = rw + 1;
                fw = -1;
                for (int f = e0; f < e0 + EMAX; f++)
                    if (fw < 0 && !einv(f - 2) && einv(f - 3)) fw = f;
                if (fw >= 0) begin
                    setb(fw + 1, 3);
                    for (int k = e0; k <= fw; k++) setb(k, 5);
                    he = fw + 1;
                end else begin
                    setb(e0 + EMAX, 1);
                    for (int k = e0; k < e0 + EMAX; k++) setb(k, 5);
                    he = e0 + EMAX;
                end
            end else begin
                setb(s + TRIG + WMAX, 2);
                he = s + TRIG + WMAX;
            end
            cx = (he > s + PER - 1) ? he : s + PER - 1;
            while (cx < N && einv(cx - 2)) cx++;
            for (int k = s; k <= cx; k++) setb(k, 0);
            if (cx >= N) break;
            c = en_a[cx] ? cx : cx + 1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, len;
        bit lvl;
        rst_n = 1'b0; en = 1'b0; ein = 1'b0;

        // Scenarios 1 and 2 as vectors; S = first frame_start cycle.
        add(0, 0, 0,   3, 7'b0000000);  // reset
        add(1, 1, 0,   1, 7'b1010001);  // S
        add(1, 1, 0,   1, 7'b1000001);  // S+1
        add(1, 1, 0,   3, 7'b1000001);  // S+4 last trig
        add(1, 1, 0,   1, 7'b0000001);  // S+5 trig fell
        add(1, 1, 0,  10, 7'b0000001);  // S+15
        add(1, 1, 1,   2, 7'b0000001);  // S+17 rise seen internally
        add(1, 1, 1,   1, 7'b0100001);  // S+18 echo_out up
        add(1, 1, 1,  17, 7'b0100001);  // S+35
        add(1, 1, 0,   2, 7'b0100001);  // S+37 last echo cycle
        add(1, 1, 0,   1, 7'b0001001);  // S+38 echo_done
        add(1, 1, 0,   1, 7'b0000001);
        add(1, 1, 0, 160, 7'b0000001);  // S+199
        add(1, 1, 0,   1, 7'b1010001);  // S+200 next frame
        add(1, 1, 0,   5, 7'b0000001);
        add(1, 1, 0,  49, 7'b0000001);  // 49 after trig fall
        add(1, 1, 0,   1, 7'b0000101);  // no_echo at 50
        add(1, 1, 0,   1, 7'b0000001);
        add(1, 1, 0, 143, 7'b0000001);
        add(1, 1, 0,   1, 7'b1010001);  // frame at 200 again
        add(1, 0, 0,   1, 7'b1000001);  // enable dropped in TRIG: frame runs on
        add(1, 0, 0, 300, 7'b0000000);  // back in IDLE
        for (int v = 0; v < nv; v++) begin
            rst_n = tbl[v].rst_n;
            en    = tbl[v].en;
            ein   = tbl[v].ein;
            repeat (tbl[v].n) tick();
            chk($sformatf("vec%0d", v), 32'(vec), 32'(tbl[v].exp));
        end

        // Timeout with echo ending before the period.
        start_frame("to_fs");
        run_frame(15, 115, 0, 0, -1, 400);
        chk("to_eout_len", r_eout, 60);
        chk("to_eout_first", r_efirst, 18);
        chk("to_pulse", r_to, 1);
        chk("to_pulse_k", r_to_k, 78);
        chk("to_no_done", r_done, 0);
        chk("to_next", r_next, 200);
        go_idle();

        // Echo held past the period end delays the retrigger.
        start_frame("long_fs");
        run_frame(15, 315, 0, 0, -1, 500);
        chk("long_to", r_to, 1);
        chk("long_eout_len", r_eout, 60);
        chk("long_next", r_next, 318);
        go_idle();

        // Echo already high at trigger, falls in WAIT_RISE, rises again.
        en = 1'b1; ein = 1'b1;
        tick();
        chk("pre_fs", 32'(frame_start), 1);
        run_frame(0, 10, 20, 35, -1, 400);
        chk("pre_eout_first", r_efirst, 23);
        chk("pre_eout_len", r_eout, 15);
        chk("pre_done", r_done, 1);
        chk("pre_done_k", r_done_k, 38);
        chk("pre_next", r_next, 200);
        go_idle();

        // Enable dropped during ECHO.
        start_frame("drop_fs");
        run_frame(15, 35, 0, 0, 25, 300);
        chk("drop_trig_len", r_trig, 5);
        chk("drop_done", r_done, 1);
        chk("drop_eout_len", r_eout, 20);
        chk("drop_idle_k", r_idle, 200);
        chk("drop_no_next", r_next, -1);
        en = 1'b1;
        tick();
        chk("reen_fs", 32'(frame_start), 1);
        chk("reen_trig", 32'(trig_out), 1);

        // Reset mid-TRIG, then mid-ECHO.
        tick(); tick();
        rst_n = 1'b0;
        tick();
        chk("rst_trig_outs", 32'(vec), 0);
        rst_n = 1'b1;
        tick();
        chk("rst_trig_restart", 32'(frame_start), 1);
        run_frame(15, 35, 0, 0, -1, 400);
        chk("rst_trig_eout", r_eout, 20);
        chk("rst_trig_next", r_next, 200);
        for (int k = 0; k < 25; k++) begin
            ein = (k >= 15);
            tick();
        end
        chk("mid_echo_high", 32'(echo_out), 1);
        rst_n = 1'b0;
        tick();
        chk("rst_echo_outs", 32'(vec), 0);
        rst_n = 1'b1; ein = 1'b0;
        tick();
        chk("rst_echo_restart", 32'(frame_start), 1);
        run_frame(15, 35, 0, 0, -1, 400);
        chk("rst_echo_done", r_done, 1);
        chk("rst_echo_next", r_next, 200);
        go_idle();

        // Random echo and enable waveforms against the frame model.
        t = 0; lvl = 1'b0;
        while (t < N) begin
            if (lvl)
                len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(150, 300))
                                                   : int'($urandom_range(1, 110));
            else
                len = int'($urandom_range(1, 90));
            for (int i = 0; i < len && t < N; i++) begin ein_a[t] = lvl; t++; end
            lvl = !lvl;
        end
        t = 0;
        while (t < N) begin
            len = int'($urandom_range(200, 900));
            for (int i = 0; i < len && t < N; i++) begin en_a[t] = 1'b1; t++; end
            len = int'($urandom_range(1, 150));
            for (int i = 0; i < len && t < N; i++) begin en_a[t] = 1'b0; t++; end
        end
        build_model();
        for (int n = 0; n < N; n++) begin
            chk($sformatf("rand_cyc%0d", n), 32'(vec), 32'(exp_a[n]));
            if (errors > 40) break;
            en  = en_a[n];
            ein = ein_a[n];
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
